// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage sitting directly behind EX.
// Takes one EX/MEM op while idle, runs a req/gnt/rvalid data-bus access for
// loads and stores, lane-aligns store data, extends load data and emits one
// registered MEM/WB result pulse per op. Upstream is stalled (in_ready=0)
// for as long as a bus access is outstanding.
module mem_stage_lsu #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MAX_WAIT       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           alu_result,
    input  logic [XLEN-1:0]           store_data,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic [2:0]                funct3,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      reg_write,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [XLEN-1:0]           dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_gnt,
    input  logic                      dmem_rvalid,
    input  logic [XLEN-1:0]           dmem_rdata,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [XLEN-1:0]           wb_data,
    output logic                      wb_reg_write,
    output logic                      exc_misalign,
    output logic                      exc_bus_err
);

    // The wait counter only has to reach MAX_WAIT-1: the last cycle in REQ or
    // WAIT is the one where the counter holds that value.
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [2:0]                f3_reg;
    logic [1:0]                off_reg;
    logic [REG_ADDR_WIDTH-1:0] rd_reg;
    logic                      rw_reg;
    logic [XLEN-1:0]           addr_reg;

    logic                      accept;
    logic                      is_mem;
    logic                      misalign;
    logic [3:0]                lane_be;
    logic [XLEN-1:0]           lane_wdata;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [XLEN-1:0]           ld_ext;

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_read || mem_write;

    // Alignment and encoding legality of the incoming memory op.
    always_comb begin
        misalign = 1'b0;
        case (funct3[1:0])
            2'b01:   misalign = alu_result[0];
            2'b10:   misalign = (alu_result[1:0] != 2'b00);
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
        if (mem_read && funct3[2] && funct3[1]) begin
            misalign = 1'b1;
        end
        if (mem_write && funct3[2]) begin
            misalign = 1'b1;
        end
    end

    // Per byte lane: enable and the store byte that lands there. Bytes are
    // replicated on all lanes, halves on both half-words, words go straight.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_be[gi] =
                (funct3[1:0] == 2'b00) ? (alu_result[1:0] == 2'(gi)) :
                (funct3[1:0] == 2'b01) ? (alu_result[1] == 1'(gi / 2)) :
                                         1'b1;
            assign lane_wdata[8*gi +: 8] =
                (funct3[1:0] == 2'b00) ? store_data[7:0] :
                (funct3[1:0] == 2'b01) ? store_data[8*(gi % 2) +: 8] :
                                         store_data[8*gi +: 8];
        end
    endgenerate

    // Load data is picked out of the returned word using the offset latched
    // at accept time, since the inputs may change while the access runs.
    assign ld_byte = dmem_rdata[{off_reg, 3'b000} +: 8];
    assign ld_half = dmem_rdata[{off_reg[1], 4'b0000} +: 16];

    // Sign/zero extension selected by the latched load size.
    always_comb begin
        case (f3_reg)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = dmem_rdata;
        endcase
    end

    // Control FSM with registered bus and writeback outputs; the result
    // flags are single-cycle pulses that default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            f3_reg       <= '0;
            off_reg      <= '0;
            rd_reg       <= '0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_be      <= '0;
            wb_valid     <= 1'b0;
            wb_rd_addr   <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus_err  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            exc_misalign <= 1'b0;
            exc_bus_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            wb_valid     <= 1'b1;
                            wb_rd_addr   <= rd_addr;
                            wb_data      <= alu_result;
                            wb_reg_write <= reg_write;
                        end else if (misalign) begin
                            wb_valid     <= 1'b1;
                            wb_rd_addr   <= rd_addr;
                            wb_data      <= alu_result;
                            exc_misalign <= 1'b1;
                        end else begin
                            state_reg  <= REQ;
                            cnt_reg    <= '0;
                            f3_reg     <= funct3;
                            off_reg    <= alu_result[1:0];
                            rd_reg     <= rd_addr;
                            rw_reg     <= reg_write;
                            addr_reg   <= alu_result;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_write;
                            dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                            dmem_be    <= lane_be;
                            dmem_wdata <= mem_write ? lane_wdata : '0;
                        end
                    end
                end
                REQ: begin
                    // A grant in the final allowed cycle still beats the timeout.
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        cnt_reg  <= '0;
                        if (dmem_we) begin
                            state_reg  <= IDLE;
                            wb_valid   <= 1'b1;
                            wb_rd_addr <= rd_reg;
                            wb_data    <= addr_reg;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        dmem_req    <= 1'b0;
                        state_reg   <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_rd_addr  <= rd_reg;
                        wb_data     <= addr_reg;
                        exc_bus_err <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_reg    <= IDLE;
                        wb_valid     <= 1'b1;
                        wb_rd_addr   <= rd_reg;
                        wb_data      <= ld_ext;
                        wb_reg_write <= rw_reg;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= IDLE;
                        wb_valid    <= 1'b1;
                        wb_rd_addr  <= rd_reg;
                        wb_data     <= addr_reg;
                        exc_bus_err <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    dmem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: self-checking bench for mem_stage_lsu.
// A transaction-level model turns each op plus its chosen grant/rvalid
// delays into per-cycle expectations; a negedge process compares them.
module tb_mem_stage_lsu;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_addr = '0;
    logic [2:0]  funct3 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        exc_misalign;
    logic        exc_bus_err;

    mem_stage_lsu #(.XLEN(32), .REG_ADDR_WIDTH(5), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr),
        .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .exc_misalign(exc_misalign),
        .exc_bus_err(exc_bus_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Per-cycle expectations
    logic        exp_ready = 1'b1;
    logic        exp_req = 1'b0;
    logic [31:0] exp_addr = '0;
    logic        exp_we = 1'b0;
    logic [3:0]  exp_be = '0;
    logic [31:0] exp_wdata = '0;
    logic        exp_wb_valid = 1'b0;
    logic [4:0]  exp_wb_rd = '0;
    logic        exp_wb_rw = 1'b0;
    logic        exp_mis = 1'b0;
    logic        exp_berr = 1'b0;
    logic        exp_data_chk = 1'b0;
    logic [31:0] exp_wb_data = '0;

    // Last observed DUT values, for the literal checks
    logic [31:0] last_wb_data, last_wb_rd, last_rw, last_mis, last_berr;
    logic [31:0] last_addr, last_be, last_wdata;

    int load_f3 [5] = '{0, 1, 2, 4, 5};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << (int'(f3) % 4);
    endfunction

    function automatic logic model_misaligned(input logic is_load, input logic [2:0] f3,
                                              input logic [31:0] a);
        logic legal;
        if (is_load) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else         legal = (f3 <= 2);
        if (!legal) return 1'b1;
        return (int'(a[1:0]) % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << size_bytes(f3)) - 1) << int'(a[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_bytes(f3))
            1:       return (d & 32'hFF) * 32'h0101_0101;
            2:       return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        logic [31:0] v;
        int off;
        off = int'(a[1:0]);
        case (size_bytes(f3))
            1: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (f3 < 4 && v >= 32'd128) v = v - 32'd256;
            end
            2: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 < 4 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, exp_ready);
            chk("dmem_req", dmem_req, exp_req);
            if (exp_req && dmem_req) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_we", dmem_we, exp_we);
                if (exp_we) begin
                    chk("dmem_be", dmem_be, exp_be);
                    chk("dmem_wdata", dmem_wdata, exp_wdata);
                end
            end
            chk("wb_valid", wb_valid, exp_wb_valid);
            if (exp_wb_valid && wb_valid) begin
                chk("wb_rd_addr", wb_rd_addr, exp_wb_rd);
                chk("wb_reg_write", wb_reg_write, exp_wb_rw);
                chk("exc_misalign", exc_misalign, exp_mis);
                chk("exc_bus_err", exc_bus_err, exp_berr);
                if (exp_data_chk) chk("wb_data", wb_data, exp_wb_data);
            end else begin
                chk("exc_misalign_idle", exc_misalign, 32'd0);
                chk("exc_bus_err_idle", exc_bus_err, 32'd0);
            end
        end
        if (wb_valid) begin
            last_wb_data = wb_data;
            last_wb_rd   = 32'(wb_rd_addr);
            last_rw      = 32'(wb_reg_write);
            last_mis     = 32'(exc_misalign);
            last_berr    = 32'(exc_bus_err);
        end
        if (dmem_req) begin
            last_addr  = dmem_addr;
            last_be    = 32'(dmem_be);
            last_wdata = dmem_wdata;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        dmem_gnt     = 1'b0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = $urandom;
        exp_ready    = 1'b1;
        exp_req      = 1'b0;
        exp_wb_valid = 1'b0;
        exp_wb_rw    = 1'b0;
        exp_mis      = 1'b0;
        exp_berr     = 1'b0;
        exp_data_chk = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic scramble();
        in_valid   = 1'b0;
        alu_result = $urandom;
        store_data = $urandom;
        rd_addr    = 5'($urandom);
        funct3     = 3'($urandom);
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        reg_write  = 1'($urandom);
    endtask

    task automatic clear_last();
        last_wb_data = 32'hDEAD_BEEF;
        last_wb_rd   = 32'hDEAD_BEEF;
        last_rw      = 32'hDEAD_BEEF;
        last_mis     = 32'hDEAD_BEEF;
        last_berr    = 32'hDEAD_BEEF;
        last_addr    = 32'hDEAD_BEEF;
        last_be      = 32'hDEAD_BEEF;
        last_wdata   = 32'hDEAD_BEEF;
    endtask

    // Presents one op in the current (idle) cycle; grant comes in REQ cycle g,
    // rvalid in WAIT cycle r (values >= MW mean never). Returns in the cycle
    // that must carry the wb pulse, with expectations for it set.
    task automatic run_op(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rdi,
                          input int g, input int r, input logic [31:0] rword);
        logic mem_op;
        logic mis;
        logic got;
        mem_op = mr || mw;
        mis = mem_op && model_misaligned(mr, f3, alu);
        in_valid = 1'b1; alu_result = alu; store_data = sd; rd_addr = rdi; funct3 = f3;
        mem_read = mr; mem_write = mw; reg_write = rw;
        next_cycle();
        scramble();
        exp_wb_rd = rdi;
        if (!mem_op || mis) begin
            exp_wb_valid = 1'b1;
            exp_wb_rw    = mem_op ? 1'b0 : rw;
            exp_mis      = mis;
            exp_data_chk = !mem_op;
            exp_wb_data  = alu;
            return;
        end
        got = 1'b0;
        for (int k = 0; k < MW; k++) begin
            exp_ready = 1'b0; exp_req = 1'b1; exp_addr = alu & 32'hFFFF_FFFC; exp_we = mw;
            exp_be = model_be(f3, alu); exp_wdata = model_wdata(f3, sd);
            if (k == g) begin
                dmem_gnt = 1'b1;
                got = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
                dmem_rvalid = 1'b1;
            end
            next_cycle();
            if (got) break;
        end
        if (got && mr) begin
            got = 1'b0;
            for (int k = 0; k < MW; k++) begin
                exp_ready = 1'b0;
                if (k == r) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rword;
                    got = 1'b1;
                end
                next_cycle();
                if (got) break;
            end
        end
        exp_wb_valid = 1'b1;
        exp_wb_rd    = rdi;
        exp_mis      = 1'b0;
        exp_berr     = !got;
        exp_wb_rw    = (got && mr) ? rw : 1'b0;
        exp_data_chk = got && mr;
        exp_wb_data  = model_load(f3, alu, rword);
    endtask

    function automatic int pick_delay();
        int s;
        s = $urandom_range(0, 9);
        if (s <= 6) return $urandom_range(0, 3);
        if (s == 7) return MW - 1;
        if (s == 8) return MW;
        return 100;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic        mr, mw;
        logic [2:0]  f3;
        logic [31:0] alu;
        int          kind;

        clear_last();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_dmem_req", dmem_req, 32'd0);
        chk("rst_dmem_we", dmem_we, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_be", dmem_be, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", wb_valid, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", {exc_misalign, exc_bus_err, wb_reg_write}, 32'd0);
        reset = 1'b0;
        next_cycle();
        chk_en = 1'b1;

        // ALU passthrough
        clear_last();
        run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 0, 0, 32'h0);
        settle();
        chk("t1_wb_data", last_wb_data, 32'h0000_1234);
        chk("t1_wb_rd", last_wb_rd, 32'd5);

        // SB to byte 3, granted in the fourth REQ cycle
        clear_last();
        run_op(1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'h1234_56AB, 5'd7, 3, 0, 32'h0);
        settle();
        chk("t2_addr", last_addr, 32'h0000_0100);
        chk("t2_be", last_be, 32'h8);
        chk("t2_wdata", last_wdata, 32'hABAB_ABAB);
        chk("t2_rw", last_rw, 32'd0);

        // LB / LBU from byte 2
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0102, 32'h0, 5'd9, 1, 2, 32'h0080_0000);
        settle();
        chk("t3_lb", last_wb_data, 32'hFFFF_FF80);
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0102, 32'h0, 5'd9, 0, 0, 32'h0080_0000);
        settle();
        chk("t3_lbu", last_wb_data, 32'h0000_0080);
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0042, 32'h0, 5'd10, 0, 1, 32'h8001_1234);
        settle();
        chk("t3_lh", last_wb_data, 32'hFFFF_8001);

        // Misaligned LW
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0202, 32'h0, 5'd4, 0, 0, 32'h0);
        settle();
        chk("t4_mis", last_mis, 32'd1);
        chk("t4_rw", last_rw, 32'd0);

        // LW granted, rvalid never arrives
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'h0, 5'd6, 0, 100, 32'h0);
        settle();
        chk("t5_berr", last_berr, 32'd1);
        chk("t5_rw", last_rw, 32'd0);
        chk("t5_ready", in_ready, 32'd1);

        // Grant and rvalid on the very last allowed cycle beat the timeout
        clear_last();
        run_op(1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0208, 32'hCAFE_F00D, 5'd8, MW - 1, 0, 32'h0);
        settle();
        chk("edge_gnt_berr", last_berr, 32'd0);
        clear_last();
        run_op(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_020C, 32'h0, 5'd8, MW - 1, MW - 1, 32'h1357_9BDF);
        settle();
        chk("edge_rv_berr", last_berr, 32'd0);
        chk("edge_rv_data", last_wb_data, 32'h1357_9BDF);

        // Asynchronous reset during REQ, then during WAIT
        chk_en = 1'b0;
        next_cycle();
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
        alu_result = 32'h0000_0300; rd_addr = 5'd3; reg_write = 1'b1;
        next_cycle();
        in_valid = 1'b0; mem_read = 1'b0;
        #2;
        chk("t6_req_before", dmem_req, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_req_drop", dmem_req, 32'd0);
        chk("t6_req_ready", in_ready, 32'd1);
        next_cycle();
        reset = 1'b0;
        in_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0300;
        next_cycle();
        in_valid = 1'b0; mem_read = 1'b0;
        dmem_gnt = 1'b1;
        next_cycle();
        next_cycle();
        #2;
        chk("t6_wait_busy", in_ready, 32'd0);
        reset = 1'b1;
        #1;
        chk("t6_wait_req", dmem_req, 32'd0);
        chk("t6_wait_wb", wb_valid, 32'd0);
        chk("t6_wait_ready", in_ready, 32'd1);
        next_cycle();
        reset = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            chk("t6_late_rvalid", wb_valid, 32'd0);
        end
        next_cycle();
        chk_en = 1'b1;

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 2);
            mr = (kind == 1);
            mw = (kind == 2);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (mr)                   f3 = 3'(load_f3[$urandom_range(0, 4)]);
            else                           f3 = 3'($urandom_range(0, 2));
            alu = $urandom;
            if ($urandom_range(0, 2) != 0) alu = alu & ~32'(size_bytes(f3) - 1);
            run_op(mr, mw, 1'($urandom), f3, alu, $urandom, 5'($urandom),
                   pick_delay(), pick_delay(), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) next_cycle();
            end
        end
        next_cycle();
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule
